eco_distancia: RTL and testbench

Echo-pulse measurement stage for the ultrasonic presence sensor. Sits directly downstream of the trigger generator `ContadorConTrigger`. It arms on the falling edge of its `trig` output, then times the sensor's asynchronous `echo` pulse and converts the width to whole centimetres. It publishes a one-cycle `valid` strobe with the distance and a registered `near` flag, which the Tamagotchi logic uses to detect a user in front of the device.

---
 rtl/eco_distancia.sv | 149 ++++++++++++++
 tb/tb_eco_distancia.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/eco_distancia.sv
// Echo-pulse timer for the ultrasonic sensor: arms on a trig falling edge, measures echo width in whole cm.
// Optional feature: define ECO_HISTERESIS_EN for a hysteresis band on the near flag.
module eco_distancia #(
    parameter int TICKS_PER_CM   = 2900,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int NEAR_CM        = 20,
    parameter int NEAR_HYST      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic       echo,
    output logic [8:0] dist_cm,
    output logic       valid,
    output logic       timeout,
    output logic       near,
    output logic       busy
);

    localparam int SUB_W = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;
    localparam int CM_W  = $clog2(MAX_CM + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_CM - 1);
    localparam logic [CM_W-1:0]  CM_MAX   = CM_W'(MAX_CM);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]       NEAR_LIM = 9'(NEAR_CM);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, DONE} state_t;

    state_t            state, state_next;
    logic [TO_W-1:0]   tcnt, tcnt_next;
    logic [SUB_W-1:0]  sub, sub_next;
    logic [CM_W-1:0]   cm, cm_next;
    logic              fire_valid, fire_to;
    logic              near_next;
    logic [8:0]        dist_new;

    logic echo_meta, echo_sync, echo_prev, trig_d;
    logic echo_rise, echo_fall, trig_fall;

    // Two flops resolve metastability on the asynchronous pin; the third is the edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain shifts by one stage per clock.
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
            trig_d    <= trig;
        end
    end

    assign echo_rise = echo_sync & ~echo_prev;
    assign echo_fall = ~echo_sync & echo_prev;
    assign trig_fall = trig_d & ~trig;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_next = state;
        tcnt_next  = tcnt;
        sub_next   = sub;
        cm_next    = cm;
        fire_valid = 1'b0;
        fire_to    = 1'b0;
        unique case (state)
            IDLE: begin
                tcnt_next = '0;
                sub_next  = '0;
                cm_next   = '0;
                if (trig_fall) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                tcnt_next = tcnt + 1'b1;
                if (tcnt == TO_LAST) begin
                    fire_to    = 1'b1;
                    state_next = IDLE;
                end else if (echo_rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                tcnt_next = tcnt + 1'b1;
                if (sub == SUB_LAST) begin
                    sub_next = '0;
                    if (cm != CM_MAX) cm_next = cm + 1'b1;
                end else begin
                    sub_next = sub + 1'b1;
                end
                // An abort wins over a coincident falling edge so valid and timeout stay exclusive.
                if (tcnt == TO_LAST) begin
                    fire_to    = 1'b1;
                    state_next = IDLE;
                end else if (echo_fall) begin
                    fire_valid = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dist_new = 9'(cm_next);

`ifdef ECO_HISTERESIS_EN
    localparam logic [8:0] NEAR_CLR = 9'(NEAR_CM + NEAR_HYST);
    always_comb begin
        near_next = near;
        if (dist_new < NEAR_LIM)       near_next = 1'b1;
        else if (dist_new >= NEAR_CLR) near_next = 1'b0;
    end
`else
    assign near_next = (dist_new < NEAR_LIM);
`endif

    // Result registers load on the edge into DONE, so valid, dist_cm and near appear together in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tcnt    <= '0;
            sub     <= '0;
            cm      <= '0;
            dist_cm <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            near    <= 1'b0;
        end else begin
            state   <= state_next;
            tcnt    <= tcnt_next;
            sub     <= sub_next;
            cm      <= cm_next;
            valid   <= fire_valid;
            timeout <= fire_to;
            if (fire_valid) begin
                dist_cm <= dist_new;
                near    <= near_next;
            end
        end
    end

    assign busy = (state == WAIT_RISE) || (state == MEASURE);

endmodule

// File: tb/tb_eco_distancia.sv
// Directed bench for eco_distancia with small parameters (10 ticks/cm, 20 cm max, 500-cycle timeout).
`timescale 1ns/1ps
module tb_eco_distancia;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic       echo;
    logic [8:0] dist_cm;
    logic       valid, timeout, near, busy;

    int n_checks = 0;
    int n_fail   = 0;

    eco_distancia #(
        .TICKS_PER_CM(10), .MAX_CM(20), .TIMEOUT_CYCLES(500), .NEAR_CM(5), .NEAR_HYST(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .echo(echo),
        .dist_cm(dist_cm), .valid(valid), .timeout(timeout), .near(near), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the first negedge where busy should already be high.
    task automatic arm();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
    endtask

    task automatic measure(input string tag, input int width, input int exp_dist, input logic exp_near);
        int         nvalid = 0;
        int         nto    = 0;
        logic [8:0] d      = '1;
        logic       n      = 1'bx;
        logic       b      = 1'bx;
        repeat (4) @(negedge clk);
        arm();
        echo = 1'b1;
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            if (valid)   nvalid++;
            if (timeout) nto++;
        end
        echo = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                d = dist_cm;
                n = near;
                b = busy;
            end
            if (timeout) nto++;
        end
        check({tag, ".valid_count"}, nvalid, 1);
        check({tag, ".dist_cm"}, d, exp_dist);
        check({tag, ".near"}, n, exp_near);
        check({tag, ".busy_at_valid"}, b, 0);
        check({tag, ".timeouts"}, nto, 0);
        check({tag, ".busy_after"}, busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int nvalid;
        logic hyst_exp;

        rst_n = 1'b0;
        trig  = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.dist_cm", dist_cm, 0);
        check("reset.valid", valid, 0);
        check("reset.timeout", timeout, 0);
        check("reset.near", near, 0);
        check("reset.busy", busy, 0);
        rst_n = 1'b1;

        measure("nominal73", 73, 7, 1'b0);
        measure("near42", 42, 4, 1'b1);
        measure("short9", 9, 0, 1'b1);
        measure("sat300", 300, 20, 1'b0);

        // No echo at all: abort exactly 500 cycles after busy rises.
        repeat (4) @(negedge clk);
        arm();
        check("to_noecho.busy_rise", busy, 1);
        lat = -1;
        nvalid = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
            if (timeout) begin
                lat = k;
                break;
            end
        end
        check("to_noecho.latency", lat, 500);
        check("to_noecho.busy_at_to", busy, 0);
        check("to_noecho.valid_count", nvalid, 0);
        check("to_noecho.dist_kept", dist_cm, 20);
        check("to_noecho.near_kept", near, 0);
        @(negedge clk);
        check("to_noecho.one_cycle", timeout, 0);

        // Echo already high when armed: no fresh rise, so it must time out.
        echo = 1'b1;
        repeat (5) @(negedge clk);
        arm();
        lat = -1;
        nvalid = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (valid) nvalid++;
            if (timeout) begin
                lat = k;
                break;
            end
        end
        check("to_stuck.latency", lat, 500);
        check("to_stuck.valid_count", nvalid, 0);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        check("to_stuck.dist_kept", dist_cm, 20);

        // Asynchronous reset 30 cycles into an echo.
        repeat (4) @(negedge clk);
        arm();
        echo = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_mid.busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.dist_cm", dist_cm, 0);
        check("rst_mid.valid", valid, 0);
        check("rst_mid.timeout", timeout, 0);
        check("rst_mid.near", near, 0);
        check("rst_mid.busy", busy, 0);
        echo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        measure("after_rst73", 73, 7, 1'b0);

        // Hysteresis sequence 4 -> 6 -> 8 cm.
`ifdef ECO_HISTERESIS_EN
        hyst_exp = 1'b1;
`else
        hyst_exp = 1'b0;
`endif
        measure("hyst4", 42, 4, 1'b1);
        measure("hyst6", 62, 6, hyst_exp);
        measure("hyst8", 82, 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
